// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block, then streams W[0..63].
// The 16-word window is stored masked as {rot, rotr(w, rot*8)}; plain words exist only on
// the combinational read/expand path. Optional macro SHA_WK_PRESUM_EN folds K[t] into out_word.
module sha256_msg_schedule #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned ROUNDS      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic [1:0]        rnd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  localparam logic [3:0] LastLoad = 4'(BLOCK_WORDS - 1);
  localparam logic [5:0] LastT    = 6'(ROUNDS - 1);

`ifdef SHA_WK_PRESUM_EN
  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  // Store form: rot tag plus the word rotated right by rot bytes.
  function automatic logic [33:0] mask_word(input logic [31:0] w, input logic [1:0] rot);
    logic [31:0] r;
    unique case (rot)
      2'd0:    r = w;
      2'd1:    r = {w[7:0], w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[23:0], w[31:24]};
    endcase
    return {rot, r};
  endfunction

  // Undo the byte rotation recorded in the tag.
  function automatic logic [31:0] unmask_word(input logic [33:0] x);
    logic [31:0] v;
    v = x[31:0];
    unique case (x[33:32])
      2'd0:    return v;
      2'd1:    return {v[23:0], v[31:24]};
      2'd2:    return {v[15:0], v[31:16]};
      default: return {v[7:0], v[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [33:0] win_q [16];
  logic [33:0] win_d [16];

  logic [3:0]  t_lo;
  logic [31:0] w_t;
  logic        in_fire, out_fire;

  // Handshake outputs; in_ready is gated by rst_n so nothing is accepted in a reset cycle.
  always_comb begin
    in_ready  = rst_n && (state_q == StLoad);
    out_valid = (state_q == StRun);
    busy      = (state_q != StLoad);
    done      = done_q;
    out_idx   = t_q;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Read/expand path: window slots are indexed modulo 16 by the low bits of t.
  always_comb begin
    t_lo = t_q[3:0];
    if (t_q[5:4] == 2'b00) begin
      w_t = unmask_word(win_q[t_lo]);
    end else begin
      w_t = sig1(unmask_word(win_q[t_lo - 4'd2])) + unmask_word(win_q[t_lo - 4'd7])
          + sig0(unmask_word(win_q[t_lo + 4'd1])) + unmask_word(win_q[t_lo]);
    end
`ifdef SHA_WK_PRESUM_EN
    out_word = w_t + K256[t_q];
`else
    out_word = w_t;
`endif
  end

  // Next-state: abort wins over any handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    done_d     = 1'b0;
    win_d      = win_q;
    if (abort) begin
      state_d    = StLoad;
      load_cnt_d = 4'd0;
      t_d        = 6'd0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            win_d[load_cnt_q] = mask_word(in_word, rnd);
            load_cnt_d        = load_cnt_q + 4'd1;
            if (load_cnt_q == LastLoad) begin
              state_d    = StRun;
              load_cnt_d = 4'd0;
              t_d        = 6'd0;
            end
          end
        end
        StRun: begin
          if (out_fire) begin
            // W[t] replaces W[t-16], which no later round needs.
            if (t_q[5:4] != 2'b00) win_d[t_lo] = mask_word(w_t, rnd);
            if (t_q == LastT) begin
              state_d = StLoad;
              t_d     = 6'd0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      load_cnt_q <= 4'd0;
      t_q        <= 6'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      done_q     <= done_d;
    end
  end

  // Window storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block, mask independence, backpressure,
// abort and mid-load reset, checked against a plain (unmasked) schedule model.
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];

  logic        clk = 1'b0;
  logic        rst_n, abort, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [1:0]  rnd;
  logic [31:0] in_word, out_word;
  logic [5:0]  out_idx;

  int n_cmp = 0;
  int n_err = 0;
  int rnd_mode = 0;
  blk_t abc_blk, blk2;

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .rnd(rnd),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

`ifdef SHA_WK_PRESUM_EN
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t model(input blk_t b);
    sched_t w;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
`ifdef SHA_WK_PRESUM_EN
    for (int i = 0; i < 64; i++) w[i] = w[i] + KT[i];
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    rnd = (rnd_mode == 4) ? 2'($urandom_range(3)) : 2'(rnd_mode);
  endtask

  // Feeds 16 words, waiting (bounded) for in_ready before each.
  task automatic load_block(input blk_t b, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int waitc;
      waitc = 0;
      in_valid = 1'b1;
      in_word  = b[i];
      while (!in_ready && waitc < 20) begin
        tick();
        waitc++;
      end
      if (!in_ready) begin
        ok = 1'b0;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0; rnd = 2'd0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    n_cmp++; if (out_idx !== 6'd0) begin n_err++;
      $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_abc();
    sched_t exp;
    bit ok;
    exp = model(abc_blk);
    rnd_mode = 4;
    load_block(abc_blk, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL abc_load got=timeout want=ready"); end
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL abc_run_entry got=v%b r%b b%b want=v1 r0 b1", out_valid, in_ready, busy); end
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL abc_idx got=v%b idx%0d want=v1 idx%0d", out_valid, out_idx, t); end
      n_cmp++; if (out_word !== exp[t]) begin n_err++;
        $display("FAIL abc_word t=%0d got=%h want=%h", t, out_word, exp[t]); end
`ifdef SHA_WK_PRESUM_EN
      if (t == 0) begin
        n_cmp++; if (out_word !== 32'hA3EC9318) begin n_err++;
          $display("FAIL abc_wk0 got=%h want=a3ec9318", out_word); end
      end
`else
      if (t == 0) begin
        n_cmp++; if (out_word !== 32'h61626380) begin n_err++;
          $display("FAIL abc_w0 got=%h want=61626380", out_word); end
      end
      if (t == 15) begin
        n_cmp++; if (out_word !== 32'h00000018) begin n_err++;
          $display("FAIL abc_w15 got=%h want=00000018", out_word); end
      end
      if (t == 16) begin
        n_cmp++; if (out_word !== 32'h61626380) begin n_err++;
          $display("FAIL abc_w16 got=%h want=61626380", out_word); end
      end
      if (t == 17) begin
        n_cmp++; if (out_word !== 32'h000F0000) begin n_err++;
          $display("FAIL abc_w17 got=%h want=000f0000", out_word); end
      end
`endif
      tick();
    end
    n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL abc_done got=d%b v%b r%b want=d1 v0 r1", done, out_valid, in_ready); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++;
      $display("FAIL abc_done_pulse got=%b want=0", done); end
    out_ready = 1'b0;
  endtask

  task automatic test_mask_independence();
    sched_t exp;
    bit ok;
    exp = model(abc_blk);
    for (int m = 0; m < 5; m++) begin
      rnd_mode = m;
      load_block(abc_blk, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++;
        $display("FAIL mask_load mode=%0d got=timeout want=ready", m); end
      out_ready = 1'b1;
      for (int t = 0; t < 64; t++) begin
        n_cmp++; if (out_word !== exp[t] || out_idx !== 6'(t)) begin n_err++;
          $display("FAIL mask_word mode=%0d t=%0d got=%h@%0d want=%h", m, t, out_word,
                   out_idx, exp[t]); end
        tick();
      end
      // Back-to-back: next load starts in the done cycle.
    end
    out_ready = 1'b0;
    rnd_mode = 4;
  endtask

  task automatic test_backpressure();
    sched_t exp;
    bit ok;
    exp = model(blk2);
    load_block(blk2, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_load got=timeout want=ready"); end
    // Junk input during RUN must be ignored.
    in_valid = 1'b1;
    in_word  = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      n_cmp++; if (out_word !== exp[t] || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL bp_pre t=%0d got=%h@%0d want=%h", t, out_word, out_idx, exp[t]); end
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_idx !== 6'd20 || out_word !== exp[20] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold k=%0d got=%h@%0d v%b want=%h@20 v1", k, out_word, out_idx,
                 out_valid, exp[20]); end
      tick();
    end
    out_ready = 1'b1;
    for (int t = 20; t < 64; t++) begin
      n_cmp++; if (out_word !== exp[t] || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL bp_post t=%0d got=%h@%0d want=%h", t, out_word, out_idx, exp[t]); end
      if (t == 63) in_valid = 1'b0;
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done got=%b want=1", done); end
    in_word = '0;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    sched_t exp2, exp;
    bit ok;
    exp2 = model(blk2);
    exp  = model(abc_blk);
    load_block(blk2, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_load got=timeout want=ready"); end
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n_cmp++; if (out_word !== exp2[t] || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL abort_pre t=%0d got=%h@%0d want=%h", t, out_word, out_idx, exp2[t]); end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL abort_flush got=v%b r%b b%b want=v0 r1 b0", out_valid, in_ready, busy); end
    n_cmp++; if (out_idx !== 6'd0 || done !== 1'b0) begin n_err++;
      $display("FAIL abort_idx got=%0d d%b want=0 d0", out_idx, done); end
    load_block(abc_blk, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_reload got=timeout want=ready"); end
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      n_cmp++; if (out_word !== exp[t] || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL abort_post t=%0d got=%h@%0d want=%h", t, out_word, out_idx, exp[t]); end
      tick();
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    sched_t exp;
    bit ok;
    exp = model(blk2);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_word  = abc_blk[i];
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
        $display("FAIL rst_pre_ready i=%0d got=%b want=1", i, in_ready); end
      tick();
    end
    in_word = abc_blk[7];
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_ready got=%b want=0", in_ready); end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_release got=r%b b%b want=r1 b0", in_ready, busy); end
    load_block(blk2, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_reload got=timeout want=ready"); end
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      n_cmp++; if (out_word !== exp[t] || out_idx !== 6'(t)) begin n_err++;
        $display("FAIL rst_post t=%0d got=%h@%0d want=%h", t, out_word, out_idx, exp[t]); end
      tick();
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_blk[i] = 32'h0;
      blk2[i]    = (32'h9E37_79B9 * 32'(i + 1)) ^ (32'(i) << 24);
    end
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    test_reset();
    test_abc();
    test_mask_independence();
    test_backpressure();
    test_abort();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
